// File: rtl/pipe_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_bus_ctrl
// Purpose  : Fixed-priority controller that connects three pipelined masters
//            (1 = VGA refill, 2 = instruction fetch, 3 = data access) to two
//            targets (1 = SRAM/blockram, 2 = peripherals). Requests are
//            decoded, arbitrated and forwarded combinationally. Read
//            responses are steered back to the issuing master through an
//            in-order tag FIFO.
// Ports    : clk25MHz, reset_n (synchronous, active-low)
//            mN_addr/rd/wr/wdata/be -> mN_wait/rdata/rvalid   (N = 1..3)
//            tK_addr/rd/wr/wdata/be <- tK_wait/rdata/rvalid   (K = 1..2)
// Params   : FIFO_DEPTH - maximum outstanding reads (power of two, >= 2)
//            PERIPH_TOP - addr[31:24] value that selects target 2
// Macro    : BUS_CTRL_PERIPH_EN - when defined, the peripheral target is
//            decoded; when undefined, all traffic goes to target 1, t2
//            outputs are tied to 0 and t2 inputs are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_bus_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] PERIPH_TOP = 8'hFF
) (
  input  logic        clk25MHz,
  input  logic        reset_n,
  // master 1 (highest priority)
  input  logic [31:0] m1_addr,
  input  logic        m1_rd,
  input  logic        m1_wr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_wait,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  // master 2
  input  logic [31:0] m2_addr,
  input  logic        m2_rd,
  input  logic        m2_wr,
  input  logic [31:0] m2_wdata,
  input  logic [3:0]  m2_be,
  output logic        m2_wait,
  output logic [31:0] m2_rdata,
  output logic        m2_rvalid,
  // master 3 (lowest priority)
  input  logic [31:0] m3_addr,
  input  logic        m3_rd,
  input  logic        m3_wr,
  input  logic [31:0] m3_wdata,
  input  logic [3:0]  m3_be,
  output logic        m3_wait,
  output logic [31:0] m3_rdata,
  output logic        m3_rvalid,
  // target 1 (SRAM / blockram)
  output logic [31:0] t1_addr,
  output logic        t1_rd,
  output logic        t1_wr,
  output logic [31:0] t1_wdata,
  output logic [3:0]  t1_be,
  input  logic        t1_wait,
  input  logic [31:0] t1_rdata,
  input  logic        t1_rvalid,
  // target 2 (peripherals)
  output logic [31:0] t2_addr,
  output logic        t2_rd,
  output logic        t2_wr,
  output logic [31:0] t2_wdata,
  output logic [3:0]  t2_be,
  input  logic        t2_wait,
  input  logic [31:0] t2_rdata,
  input  logic        t2_rvalid
);

  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  // ---------------------------------------------------------------- grant
  logic [2:0]  w_req;
  logic [2:0]  w_gnt;
  logic [31:0] w_g_addr;
  logic [31:0] w_g_wdata;
  logic [3:0]  w_g_be;
  logic        w_g_rd;
  logic        w_g_wr;
  logic [1:0]  w_g_mid;

  always_comb begin
    w_req     = {m3_rd | m3_wr, m2_rd | m2_wr, m1_rd | m1_wr};
    w_gnt     = 3'b000;
    w_g_addr  = '0;
    w_g_wdata = '0;
    w_g_be    = '0;
    w_g_rd    = 1'b0;
    w_g_wr    = 1'b0;
    w_g_mid   = 2'd0;
    if (w_req[0]) begin
      w_gnt     = 3'b001;
      w_g_addr  = m1_addr;
      w_g_wdata = m1_wdata;
      w_g_be    = m1_be;
      w_g_rd    = m1_rd;
      w_g_wr    = m1_wr;
      w_g_mid   = 2'd1;
    end else if (w_req[1]) begin
      w_gnt     = 3'b010;
      w_g_addr  = m2_addr;
      w_g_wdata = m2_wdata;
      w_g_be    = m2_be;
      w_g_rd    = m2_rd;
      w_g_wr    = m2_wr;
      w_g_mid   = 2'd2;
    end else if (w_req[2]) begin
      w_gnt     = 3'b100;
      w_g_addr  = m3_addr;
      w_g_wdata = m3_wdata;
      w_g_be    = m3_be;
      w_g_rd    = m3_rd;
      w_g_wr    = m3_wr;
      w_g_mid   = 2'd3;
    end
  end

  // ------------------------------------------------------------- tag FIFO
  // Entry layout: {master id[1:0], target id (0 = t1, 1 = t2)}
  logic [2:0]         r_tag_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;

  logic w_full;
  logic w_empty;
  logic w_last_tid;
  logic w_head_tid;
  logic [1:0] w_head_mid;

  assign w_full     = (r_count == c_cnt_w'(FIFO_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_last_tid = r_tag_mem[r_wr_ptr - c_ptr_w'(1)][0];
  assign w_head_tid = r_tag_mem[r_rd_ptr][0];
  assign w_head_mid = r_tag_mem[r_rd_ptr][2:1];

  // -------------------------------------- decode and target-2 input gating
  logic        w_sel_t2;
  logic        w_xstall;
  logic        w_t2_wait_eff;
  logic        w_t2_rvalid_eff;
  logic [31:0] w_t2_rdata_eff;

`ifdef BUS_CTRL_PERIPH_EN
  assign w_sel_t2        = (w_g_addr[31:24] == PERIPH_TOP);
  // A read to the other target must wait until everything queued ahead of
  // it has drained, otherwise the two targets could answer out of order.
  assign w_xstall        = ~w_empty & (w_last_tid != w_sel_t2);
  assign w_t2_wait_eff   = t2_wait;
  assign w_t2_rvalid_eff = t2_rvalid;
  assign w_t2_rdata_eff  = t2_rdata;
`else
  logic w_unused_t2;
  assign w_sel_t2        = 1'b0;
  assign w_xstall        = 1'b0;
  assign w_t2_wait_eff   = 1'b0;
  assign w_t2_rvalid_eff = 1'b0;
  assign w_t2_rdata_eff  = '0;
  assign w_unused_t2     = ^{t2_wait, t2_rvalid, t2_rdata, PERIPH_TOP, w_last_tid};
`endif

  // ------------------------------------------------------------ forwarding
  logic w_stall;
  logic w_twait;
  logic w_fwd;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_rsp_valid;
  logic [31:0] w_rsp_data;

  assign w_stall  = w_g_rd & (w_full | w_xstall);
  assign w_twait  = w_sel_t2 ? w_t2_wait_eff : t1_wait;
  assign w_fwd    = reset_n & ~w_stall;
  assign w_accept = reset_n & (w_g_rd | w_g_wr) & ~w_stall & ~w_twait;
  assign w_push   = w_accept & w_g_rd;

  assign t1_rd    = w_fwd & ~w_sel_t2 & w_g_rd;
  assign t1_wr    = w_fwd & ~w_sel_t2 & w_g_wr;
  assign t1_addr  = w_sel_t2 ? 32'd0 : w_g_addr;
  assign t1_wdata = w_sel_t2 ? 32'd0 : w_g_wdata;
  assign t1_be    = w_sel_t2 ? 4'd0  : w_g_be;

`ifdef BUS_CTRL_PERIPH_EN
  assign t2_rd    = w_fwd & w_sel_t2 & w_g_rd;
  assign t2_wr    = w_fwd & w_sel_t2 & w_g_wr;
  assign t2_addr  = w_sel_t2 ? w_g_addr  : 32'd0;
  assign t2_wdata = w_sel_t2 ? w_g_wdata : 32'd0;
  assign t2_be    = w_sel_t2 ? w_g_be    : 4'd0;
`else
  assign t2_rd    = 1'b0;
  assign t2_wr    = 1'b0;
  assign t2_addr  = 32'd0;
  assign t2_wdata = 32'd0;
  assign t2_be    = 4'd0;
`endif

  // A loser always waits; the winner waits on its target or a read stall.
  assign m1_wait = ~reset_n | (w_req[0] & (~w_gnt[0] | w_stall | w_twait));
  assign m2_wait = ~reset_n | (w_req[1] & (~w_gnt[1] | w_stall | w_twait));
  assign m3_wait = ~reset_n | (w_req[2] & (~w_gnt[2] | w_stall | w_twait));

  // -------------------------------------------------------- response path
  // Only the head entry's target may complete a read; anything else is noise.
  assign w_rsp_valid = reset_n & ~w_empty & (w_head_tid ? w_t2_rvalid_eff : t1_rvalid);
  assign w_rsp_data  = w_head_tid ? w_t2_rdata_eff : t1_rdata;
  assign w_pop       = w_rsp_valid;

  assign m1_rvalid = w_rsp_valid & (w_head_mid == 2'd1);
  assign m2_rvalid = w_rsp_valid & (w_head_mid == 2'd2);
  assign m3_rvalid = w_rsp_valid & (w_head_mid == 2'd3);
  assign m1_rdata  = m1_rvalid ? w_rsp_data : 32'd0;
  assign m2_rdata  = m2_rvalid ? w_rsp_data : 32'd0;
  assign m3_rdata  = m3_rvalid ? w_rsp_data : 32'd0;

  // ------------------------------------------------------------ FIFO state
  always_ff @(posedge clk25MHz) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read while count != 0.
  always_ff @(posedge clk25MHz) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= {w_g_mid, w_sel_t2};
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_bus_ctrl
// Purpose  : Self-checking bench for pipe_bus_ctrl. Directed stimulus checks
//            the combinational request path and pushes the expected read
//            responses into a scoreboard queue; a monitor pops and compares
//            whenever any master sees rvalid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_bus_ctrl;

  logic        clk25MHz = 1'b0;
  logic        reset_n;
  logic [31:0] m1_addr, m2_addr, m3_addr;
  logic        m1_rd, m2_rd, m3_rd, m1_wr, m2_wr, m3_wr;
  logic [31:0] m1_wdata, m2_wdata, m3_wdata;
  logic [3:0]  m1_be, m2_be, m3_be;
  logic        m1_wait, m2_wait, m3_wait;
  logic [31:0] m1_rdata, m2_rdata, m3_rdata;
  logic        m1_rvalid, m2_rvalid, m3_rvalid;
  logic [31:0] t1_addr, t2_addr, t1_wdata, t2_wdata;
  logic        t1_rd, t2_rd, t1_wr, t2_wr;
  logic [3:0]  t1_be, t2_be;
  logic        t1_wait, t2_wait, t1_rvalid, t2_rvalid;
  logic [31:0] t1_rdata, t2_rdata;

  pipe_bus_ctrl #(.FIFO_DEPTH(4), .PERIPH_TOP(8'hFF)) dut (
    .clk25MHz(clk25MHz), .reset_n(reset_n),
    .m1_addr(m1_addr), .m1_rd(m1_rd), .m1_wr(m1_wr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_wait(m1_wait), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .m2_addr(m2_addr), .m2_rd(m2_rd), .m2_wr(m2_wr), .m2_wdata(m2_wdata), .m2_be(m2_be),
    .m2_wait(m2_wait), .m2_rdata(m2_rdata), .m2_rvalid(m2_rvalid),
    .m3_addr(m3_addr), .m3_rd(m3_rd), .m3_wr(m3_wr), .m3_wdata(m3_wdata), .m3_be(m3_be),
    .m3_wait(m3_wait), .m3_rdata(m3_rdata), .m3_rvalid(m3_rvalid),
    .t1_addr(t1_addr), .t1_rd(t1_rd), .t1_wr(t1_wr), .t1_wdata(t1_wdata), .t1_be(t1_be),
    .t1_wait(t1_wait), .t1_rdata(t1_rdata), .t1_rvalid(t1_rvalid),
    .t2_addr(t2_addr), .t2_rd(t2_rd), .t2_wr(t2_wr), .t2_wdata(t2_wdata), .t2_be(t2_be),
    .t2_wait(t2_wait), .t2_rdata(t2_rdata), .t2_rvalid(t2_rvalid)
  );

  always #20 clk25MHz = ~clk25MHz;

  typedef struct {
    logic [1:0]  mid;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [1:0] mid, input logic [31:0] d);
    exp_t e;
    e.mid  = mid;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk25MHz);
    #1;
  endtask

  task automatic idle();
    m1_rd = 0; m2_rd = 0; m3_rd = 0;
    m1_wr = 0; m2_wr = 0; m3_wr = 0;
    t1_rvalid = 0; t2_rvalid = 0;
  endtask

  // --------------------------------------------------------------- monitor
  logic [2:0] mon_rv;
  logic [2:0] mon_exp_rv;
  exp_t       mon_e;

  always @(negedge clk25MHz) begin
    mon_rv = {m3_rvalid, m2_rvalid, m1_rvalid};
    if (mon_rv != 3'b000) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", {29'd0, mon_rv}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        case (mon_e.mid)
          2'd1:    mon_exp_rv = 3'b001;
          2'd2:    mon_exp_rv = 3'b010;
          default: mon_exp_rv = 3'b100;
        endcase
        check("rsp_route", {29'd0, mon_rv}, {29'd0, mon_exp_rv});
        check("rsp_m1_rdata", m1_rdata, (mon_e.mid == 2'd1) ? mon_e.data : 32'd0);
        check("rsp_m2_rdata", m2_rdata, (mon_e.mid == 2'd2) ? mon_e.data : 32'd0);
        check("rsp_m3_rdata", m3_rdata, (mon_e.mid == 2'd3) ? mon_e.data : 32'd0);
      end
    end
  end

  // ------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  // -------------------------------------------------------------- stimulus
  initial begin
    reset_n = 0;
    m1_addr = 0; m2_addr = 0; m3_addr = 0;
    m1_wdata = 0; m2_wdata = 0; m3_wdata = 0;
    m1_be = 0; m2_be = 0; m3_be = 0;
    t1_wait = 0; t2_wait = 0; t1_rdata = 0; t2_rdata = 0;
    idle();

    // reset: strobes blocked, all waits high, no responses
    cyc();
    m1_rd = 1; m1_addr = 32'h4000_0000; t1_rvalid = 1;
    #1;
    check("rst_t1_rd", {31'd0, t1_rd}, 32'd0);
    check("rst_m1_wait", {31'd0, m1_wait}, 32'd1);
    check("rst_m2_wait", {31'd0, m2_wait}, 32'd1);
    check("rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    cyc();
    idle(); reset_n = 1;
    #1;
    check("idle_m1_wait", {31'd0, m1_wait}, 32'd0);

    // priority: all three read the same address
    cyc();
    m1_rd = 1; m2_rd = 1; m3_rd = 1;
    m1_addr = 32'h4000_0000; m2_addr = 32'h4000_0000; m3_addr = 32'h4000_0000;
    #1;
    check("pri_t1_rd", {31'd0, t1_rd}, 32'd1);
    check("pri_t1_addr", t1_addr, 32'h4000_0000);
    check("pri_m1_wait", {31'd0, m1_wait}, 32'd0);
    check("pri_m2_wait", {31'd0, m2_wait}, 32'd1);
    check("pri_m3_wait", {31'd0, m3_wait}, 32'd1);
    check("pri_t2_rd", {31'd0, t2_rd}, 32'd0);
    exp_push(2'd1, 32'h0000_00A1);
    cyc();
    m1_rd = 0;
    #1;
    check("pri2_t1_rd", {31'd0, t1_rd}, 32'd1);
    check("pri2_m2_wait", {31'd0, m2_wait}, 32'd0);
    check("pri2_m3_wait", {31'd0, m3_wait}, 32'd1);
    exp_push(2'd2, 32'h0000_00A2);
    cyc(); idle(); t1_rvalid = 1; t1_rdata = 32'h0000_00A1;
    cyc(); t1_rdata = 32'h0000_00A2;
    cyc(); idle();

    // decode: peripheral write
    cyc();
    m3_wr = 1; m3_addr = 32'hFF00_0000; m3_wdata = 32'h0000_0041; m3_be = 4'b0001;
    #1;
    check("dec_m3_wait", {31'd0, m3_wait}, 32'd0);
`ifdef BUS_CTRL_PERIPH_EN
    check("dec_t2_wr", {31'd0, t2_wr}, 32'd1);
    check("dec_t2_wdata", t2_wdata, 32'h0000_0041);
    check("dec_t2_be", {28'd0, t2_be}, 32'd1);
    check("dec_t2_addr", t2_addr, 32'hFF00_0000);
    check("dec_t1_wr", {31'd0, t1_wr}, 32'd0);
`else
    check("dec_t1_wr", {31'd0, t1_wr}, 32'd1);
    check("dec_t1_wdata", t1_wdata, 32'h0000_0041);
    check("dec_t2_wr", {31'd0, t2_wr}, 32'd0);
`endif
    // write left no FIFO entry: stray rvalids route nowhere
    cyc(); idle(); t1_rvalid = 1; t2_rvalid = 1;
    #1;
    check("dec_no_entry", {29'd0, m3_rvalid, m2_rvalid, m1_rvalid}, 32'd0);
    cyc(); idle();

    // routing, including a target wait and a simultaneous push/pop
    cyc();
    m2_rd = 1; m2_addr = 32'h4000_0010; t1_wait = 1;
    #1;
    check("rt_tw_m2_wait", {31'd0, m2_wait}, 32'd1);
    cyc();
    t1_wait = 0;
    #1;
    check("rt_m2_wait", {31'd0, m2_wait}, 32'd0);
    check("rt_t1_addr", t1_addr, 32'h4000_0010);
    exp_push(2'd2, 32'h0000_1111);
    cyc();
    m2_rd = 0; m3_rd = 1; m3_addr = 32'h4000_0014;
    t1_rvalid = 1; t1_rdata = 32'h0000_1111;
    #1;
    check("rt_m3_wait", {31'd0, m3_wait}, 32'd0);
    check("rt_t1_addr2", t1_addr, 32'h4000_0014);
    exp_push(2'd3, 32'h0000_2222);
    cyc(); m3_rd = 0; t1_rdata = 32'h0000_2222;
    cyc(); idle();

    // full: five back-to-back reads with no data returning
    m3_addr = 32'h4000_0100;
    for (int i = 0; i < 4; i++) begin
      cyc();
      m3_rd = 1;
      #1;
      check("full_acc_t1_rd", {31'd0, t1_rd}, 32'd1);
      check("full_acc_m3_wait", {31'd0, m3_wait}, 32'd0);
      exp_push(2'd3, 32'h0000_00F0 + 32'(i));
    end
    cyc();
    #1;
    check("full_stall_m3_wait", {31'd0, m3_wait}, 32'd1);
    check("full_stall_t1_rd", {31'd0, t1_rd}, 32'd0);
    cyc();
    t1_rvalid = 1; t1_rdata = 32'h0000_00F0;
    #1;
    check("full_pop_cyc_wait", {31'd0, m3_wait}, 32'd1);
    cyc();
    t1_rvalid = 0;
    #1;
    check("full_release_wait", {31'd0, m3_wait}, 32'd0);
    check("full_release_t1_rd", {31'd0, t1_rd}, 32'd1);
    exp_push(2'd3, 32'h0000_00F4);
    cyc(); m3_rd = 0; t1_rvalid = 1; t1_rdata = 32'h0000_00F1;
    cyc(); t1_rdata = 32'h0000_00F2;
    cyc(); t1_rdata = 32'h0000_00F3;
    cyc(); t1_rdata = 32'h0000_00F4;
    cyc(); idle();

    // cross-target ordering
    cyc();
    m1_rd = 1; m1_addr = 32'h4000_0000;
    #1;
    check("x_t1_rd", {31'd0, t1_rd}, 32'd1);
    exp_push(2'd1, 32'h0000_00C1);
    cyc();
    m1_rd = 0; m3_rd = 1; m3_addr = 32'hFF00_0001;
`ifdef BUS_CTRL_PERIPH_EN
    t2_rvalid = 1; t2_rdata = 32'hBAD0_0000;
    #1;
    check("x_stall_wait", {31'd0, m3_wait}, 32'd1);
    check("x_stall_t2_rd", {31'd0, t2_rd}, 32'd0);
    check("x_t2_ignored", {29'd0, m3_rvalid, m2_rvalid, m1_rvalid}, 32'd0);
    cyc();
    t2_rvalid = 0;
    #1;
    check("x_stall2_wait", {31'd0, m3_wait}, 32'd1);
    cyc();
    t1_rvalid = 1; t1_rdata = 32'h0000_00C1;
    #1;
    check("x_pop_cyc_wait", {31'd0, m3_wait}, 32'd1);
    cyc();
    t1_rvalid = 0;
    #1;
    check("x_acc_wait", {31'd0, m3_wait}, 32'd0);
    check("x_acc_t2_rd", {31'd0, t2_rd}, 32'd1);
    check("x_acc_t2_addr", t2_addr, 32'hFF00_0001);
    exp_push(2'd3, 32'h0000_00C2);
    cyc(); m3_rd = 0; t2_rvalid = 1; t2_rdata = 32'h0000_00C2;
    cyc(); idle();
`else
    #1;
    check("x_nop_wait", {31'd0, m3_wait}, 32'd0);
    check("x_nop_t1_rd", {31'd0, t1_rd}, 32'd1);
    check("x_nop_t2_rd", {31'd0, t2_rd}, 32'd0);
    exp_push(2'd3, 32'h0000_00C2);
    cyc(); m3_rd = 0; t1_rvalid = 1; t1_rdata = 32'h0000_00C1;
    cyc(); t1_rdata = 32'h0000_00C2;
    cyc(); idle();
`endif

    // reset with two reads outstanding
    cyc();
    m1_rd = 1; m1_addr = 32'h4000_0000;
    #1;
    check("rm_t1_rd", {31'd0, t1_rd}, 32'd1);
    cyc();
    cyc();
    m1_rd = 0; reset_n = 0;
    #1;
    check("rm_m2_wait", {31'd0, m2_wait}, 32'd1);
    cyc();
    reset_n = 1; t1_rvalid = 1; t1_rdata = 32'hDEAD_BEEF;
    #1;
    check("rm_stray", {29'd0, m3_rvalid, m2_rvalid, m1_rvalid}, 32'd0);
    cyc();
    t1_rvalid = 0; m2_rd = 1; m2_addr = 32'h4000_0020;
    #1;
    check("rm_fresh_t1_rd", {31'd0, t1_rd}, 32'd1);
    check("rm_fresh_m2_wait", {31'd0, m2_wait}, 32'd0);
    exp_push(2'd2, 32'h0000_00E1);
    cyc(); m2_rd = 0; t1_rvalid = 1; t1_rdata = 32'h0000_00E1;
    cyc(); idle();
    cyc();
    cyc();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
